// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a sequencing controller and the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - borrow_in, LSB first, one bit per clock through
// a single full-subtractor cell and a borrow flip-flop. Results are held until
// the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   acc;
  logic               br;
  logic [CNT_W-1:0]   cnt;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic               overflow_r;

  logic               accept;
  logic               last;
  logic               d;
  logic               br_nxt;
  logic [WIDTH-1:0]   acc_nxt;

  // Full-subtractor difference bit.
  function automatic logic sub_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  // Full-subtractor borrow: borrow when x < y, or x == y with an incoming borrow.
  function automatic logic sub_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  // A new request is taken whenever no bits are in flight.
  assign accept  = (state != SHIFT) && bus.start;
  assign last    = (state == SHIFT) && (cnt == LAST);
  assign d       = sub_diff(a_sr[0], b_sr[0], br);
  assign br_nxt  = sub_borrow(a_sr[0], b_sr[0], br);
  // New bit enters at the MSB so that after WIDTH steps bit 0 is the first result bit.
  assign acc_nxt = (acc >> 1) | ({{(WIDTH-1){1'b0}}, d} << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; SHIFT ignores start so operands are never re-sampled mid-operation.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_sr       <= '0;
      b_sr       <= '0;
      acc        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      diff_r     <= '0;
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      br   <= bus.borrow_in;
      cnt  <= '0;
      sa   <= bus.a[WIDTH-1];
      sb   <= bus.b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      acc  <= acc_nxt;
      br   <= br_nxt;
      cnt  <= cnt + 1'b1;
      if (last) begin
        diff_r     <= acc_nxt;
        borrow_r   <= br_nxt;
        // Signed overflow: operand signs differ and the result sign differs from the minuend.
        overflow_r <= (sa ^ sb) & (sa ^ d);
      end
    end
  end

  assign bus.busy       = (state == SHIFT);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_r;
  assign bus.overflow   = overflow_r;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial full subtractor: accepts two WIDTH-bit operands plus a borrow-in and computes a − b − borrow_in LSB-first, one bit per clock, through a single registered full-subtractor cell with a borrow flip-flop. It is the inverse arithmetic counterpart of the existing registered full_adder and sits beside it in the arithmetic verification set. It trades latency for area and provides a start/busy/done handshake for a sequencing controller.

## Interface

- WIDTH, default 8, operand and result width in bits (≥ 2).

- clk  input  1  single clock; all state changes on its rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a subtraction; sampled only when not busy.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- borrow_in  input  1  initial borrow, captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result a − b − borrow_in (mod 2^WIDTH), held until the next completion.
- borrow_out  output  1  final borrow (unsigned underflow), held with diff.
- overflow  output  1  signed overflow of the subtraction, held with diff.

## Operation

- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE or DONE with start=1: load a_sr←a, b_sr←b, br←borrow_in, cnt←0, capture a[WIDTH-1] and b[WIDTH-1] sign bits, go to SHIFT. DONE with start=0 goes to IDLE.
- SHIFT, each cycle:
  - d = a_sr[0] ^ b_sr[0] ^ br.
  - br ← (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - Shift a_sr and b_sr right by 1. Shift d into the MSB of the working register acc.
  - Increment cnt.
- When cnt = WIDTH−1 in SHIFT, perform the last bit and go to DONE. On the same edge:
  - diff ← final acc value, including this bit.
  - borrow_out ← final br.
  - overflow ← (sa ^ sb) & (sa ^ diff_msb), where sa and sb are the captured sign bits.
- diff, borrow_out and overflow update only on entry to DONE. They are stable at all other times, including during the next operation.
- start in SHIFT is ignored. Operands are never re-sampled mid-operation.
- busy = (state == SHIFT). done = (state == DONE). Both are registered-state decodes, with no combinational path from inputs.
- Arithmetic: result is modulo 2^WIDTH. borrow_out=1 exactly when a < b + borrow_in, treated as unsigned.

## Timing

- Reset (rstn low, asynchronous) forces the following immediately, regardless of the clock, including mid-SHIFT:
  - state=IDLE, busy=0, done=0.
  - diff=0, borrow_out=0, overflow=0.
  - a_sr, b_sr, acc, br and cnt all 0.
- After rstn deasserts, the first start is accepted on the first rising edge at which it is high.
- Latency: start accepted at edge E.
  - busy is high for cycles E+1 … E+WIDTH.
  - done is high for exactly one cycle, after edge E+WIDTH.
  - Results are valid from edge E+WIDTH.
- Back-to-back: start held high during the done cycle is accepted. In that case busy rises on the next edge, with no IDLE cycle, so throughput is one operation per WIDTH+1 cycles.
- start held continuously triggers repeated operations. The operands are re-captured at each acceptance.

## Test plan

- Basic: WIDTH=8, a=0x05, b=0x03, borrow_in=0, pulse start → after 8 busy cycles, one done pulse; diff=0x02, borrow_out=0, overflow=0.
- Underflow: a=0x03, b=0x05, borrow_in=0 → diff=0xFE, borrow_out=1, overflow=0. Then a=0x00, b=0x00, borrow_in=1 → diff=0xFF, borrow_out=1.
- Signed overflow: a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF → diff=0x80, borrow_out=1, overflow=1.
- Handshake:
  - start pulsed mid-operation with different operands → ignored; the result matches the original operands; busy stays exactly 8 cycles.
  - start held through done → a second operation starts with no idle cycle.
- Reset mid-operation: assert rstn=0 at busy cycle 4 → busy, done, diff, borrow_out and overflow go to 0 immediately. After release, a fresh a=0x10, b=0x01 gives diff=0x0F.
- Exhaustive: WIDTH=4, all 512 (a, b, borrow_in) combinations → diff, borrow_out and overflow match a reference model; done is asserted exactly once per start.
